// File: rtl/uart_pkg.sv
// Shared UART constants and FSM encoding, common to the transmitter and receiver.
package uart_pkg;

    localparam int unsigned CLK_FREQ       = 27000000;
    localparam int unsigned BAUD_RATE_1200 = 1200;
    localparam int unsigned BAUD_RATE_2400 = 2400;

    localparam int unsigned MSG_SIZE       = 6;
    localparam int unsigned CODED_MSG_SIZE = 2 * (MSG_SIZE + 2);
    localparam int unsigned IDX_W          = $clog2(CODED_MSG_SIZE);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b10,
        STOP  = 2'b11
    } uart_state_e;

endpackage

// File: rtl/conv_encode.sv
// Rate-1/2, K=3 convolutional encoder (g0=111, g1=101) with two zero tail bits.
module conv_encode
    import uart_pkg::*;
(
    input  logic [MSG_SIZE-1:0]       msg_in,
    output logic [CODED_MSG_SIZE-1:0] msg_out
);

    localparam int unsigned STEPS = CODED_MSG_SIZE / 2;
    localparam int unsigned STEP_W = $clog2(STEPS);

    function automatic logic [CODED_MSG_SIZE-1:0] encode(input logic [MSG_SIZE-1:0] m);
        logic [STEPS-1:0]          u_seq;
        logic [CODED_MSG_SIZE-1:0] c;
        logic                      u;
        logic                      s1;
        logic                      s2;
        u_seq = STEPS'(m);
        c     = '0;
        s1    = 1'b0;
        s2    = 1'b0;
        for (int i = 0; i < STEPS; i++) begin
            u = u_seq[STEP_W'(i)];
            c[IDX_W'(2 * i)]     = u ^ s1 ^ s2;
            c[IDX_W'(2 * i + 1)] = u ^ s2;
            s2 = s1;
            s1 = u;
        end
        return c;
    endfunction

    assign msg_out = encode(msg_in);

endmodule

// File: rtl/uart_transmitter.sv
// UART frame generator: start bit, raw or convolutionally coded payload LSB first, stop bit.
module uart_transmitter #(
    parameter int unsigned CLK_FREQ       = uart_pkg::CLK_FREQ,
    parameter int unsigned BAUD_RATE_1200 = uart_pkg::BAUD_RATE_1200,
    parameter int unsigned BAUD_RATE_2400 = uart_pkg::BAUD_RATE_2400
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [uart_pkg::MSG_SIZE-1:0] data_in,
    input  logic                         msg_select,
    input  logic                         baud_select,
    output logic                         tx,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned MSG_SIZE       = uart_pkg::MSG_SIZE;
    localparam int unsigned CODED_MSG_SIZE = uart_pkg::CODED_MSG_SIZE;
    localparam int unsigned IDX_W          = uart_pkg::IDX_W;
    localparam int unsigned CNT_W          = 32;
    localparam int unsigned TICKS_FAST     = CLK_FREQ / BAUD_RATE_2400;
    localparam int unsigned TICKS_SLOW     = CLK_FREQ / BAUD_RATE_1200;

    uart_pkg::uart_state_e       r_state, w_state_nxt;
    logic [CODED_MSG_SIZE-1:0]   r_shreg, w_shreg_nxt;
    logic [CNT_W-1:0]            r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0]            r_ticks, w_ticks_nxt;
    logic [IDX_W-1:0]            r_idx, w_idx_nxt;
    logic [IDX_W-1:0]            r_last, w_last_nxt;
    logic                        r_tx, w_tx_nxt;
    logic                        r_busy, w_busy_nxt;
    logic                        r_done, w_done_nxt;
    logic [CODED_MSG_SIZE-1:0]   w_coded;
    logic                        w_bit_end;

    conv_encode u_conv_encode (
        .msg_in  (data_in),
        .msg_out (w_coded)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= uart_pkg::IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_ticks <= '0;
            r_idx   <= '0;
            r_last  <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shreg <= w_shreg_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ticks <= w_ticks_nxt;
            r_idx   <= w_idx_nxt;
            r_last  <= w_last_nxt;
            r_tx    <= w_tx_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state and next-output logic; outputs are registered from these values.
    always_comb begin
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_cnt_nxt   = r_cnt;
        w_ticks_nxt = r_ticks;
        w_idx_nxt   = r_idx;
        w_last_nxt  = r_last;
        w_tx_nxt    = 1'b1;
        w_busy_nxt  = 1'b1;
        w_bit_end   = (r_cnt == r_ticks - CNT_W'(1));

        case (r_state)
            uart_pkg::IDLE: begin
                w_busy_nxt = 1'b0;
                if (start) begin
                    w_state_nxt = uart_pkg::START;
                    w_shreg_nxt = msg_select ? w_coded : CODED_MSG_SIZE'(data_in);
                    w_last_nxt  = msg_select ? IDX_W'(CODED_MSG_SIZE - 1) : IDX_W'(MSG_SIZE - 1);
                    w_ticks_nxt = baud_select ? CNT_W'(TICKS_FAST) : CNT_W'(TICKS_SLOW);
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_tx_nxt    = 1'b0;
                    w_busy_nxt  = 1'b1;
                end
            end
            uart_pkg::START: begin
                w_tx_nxt = 1'b0;
                if (w_bit_end) begin
                    w_state_nxt = uart_pkg::DATA;
                    w_cnt_nxt   = '0;
                    w_tx_nxt    = r_shreg[r_idx];
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            uart_pkg::DATA: begin
                w_tx_nxt = r_shreg[r_idx];
                if (w_bit_end) begin
                    w_cnt_nxt = '0;
                    if (r_idx == r_last) begin
                        w_state_nxt = uart_pkg::STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + IDX_W'(1);
                        w_tx_nxt  = r_shreg[w_idx_nxt];
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            uart_pkg::STOP: begin
                if (w_bit_end) begin
                    w_state_nxt = uart_pkg::IDLE;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = uart_pkg::IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase

        // done is registered, so it is raised when the final stop-bit cycle is about to begin
        w_done_nxt = (w_state_nxt == uart_pkg::STOP) && (w_cnt_nxt == r_ticks - CNT_W'(1));
    end

    assign tx   = r_tx;
    assign busy = r_busy;
    assign done = r_done;

endmodule
